// File: rtl/negedge_detector.sv
// Registered falling-edge detector: one-clock pulse per lane when a lane's sample goes 1 -> 0.
// Optional event counter is enabled by defining NEGEDGE_DETECTOR_COUNT_EN.
module negedge_detector #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0
`ifdef NEGEDGE_DETECTOR_COUNT_EN
  ,
  parameter int CNT_WIDTH   = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     signal_in,
`ifdef NEGEDGE_DETECTOR_COUNT_EN
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] edge_count,
`endif
  output logic [WIDTH-1:0]     negedge_detected
);

  logic [WIDTH-1:0] w_s_p0;
  logic [WIDTH-1:0] w_fall_p1;
  logic [WIDTH-1:0] r_prev_p1;
  logic [WIDTH-1:0] r_pulse_p2;

  // p0: optional synchronizer; w_s_p0 is the sample the detector sees
  generate
    if (SYNC_STAGES == 1 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("negedge_detector: SYNC_STAGES must be 0 or 2..4");
    end

    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s_p0 = signal_in;
    end else begin : g_sync
      logic [WIDTH-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
          r_sync[0] <= signal_in;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end

      assign w_s_p0 = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // p1: previous sample register; p2: registered pulse
  assign w_fall_p1 = r_prev_p1 & ~w_s_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_p1  <= '0;
      r_pulse_p2 <= '0;
    end else begin
      r_prev_p1  <= w_s_p0;
      r_pulse_p2 <= w_fall_p1;
    end
  end

  assign negedge_detected = r_pulse_p2;

`ifdef NEGEDGE_DETECTOR_COUNT_EN
  // Counter keys off the pulse being loaded, so it moves on the same edge the pulse appears
  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if ((|w_fall_p1) && (r_count != {CNT_WIDTH{1'b1}})) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign edge_count = r_count;
`endif

endmodule

// File: tb/tb_negedge_detector.sv
// Directed bench for negedge_detector: single lane, four lanes, two-stage synchronizer,
// and the optional counter when NEGEDGE_DETECTOR_COUNT_EN is defined.
module tb_negedge_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig_w1;
  logic [3:0] sig_w4;
  logic       sig_s2;
  logic       out_w1;
  logic [3:0] out_w4;
  logic       out_s2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef NEGEDGE_DETECTOR_COUNT_EN
  logic       sig_c;
  logic       out_c;
  logic       cnt_clr;
  logic [1:0] cnt_c;
  logic [15:0] cnt_w1, cnt_w4, cnt_s2;
`endif

  negedge_detector #(.WIDTH(1), .SYNC_STAGES(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .signal_in(sig_w1),
`ifdef NEGEDGE_DETECTOR_COUNT_EN
    .cnt_clr(1'b0), .edge_count(cnt_w1),
`endif
    .negedge_detected(out_w1)
  );

  negedge_detector #(.WIDTH(4), .SYNC_STAGES(0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .signal_in(sig_w4),
`ifdef NEGEDGE_DETECTOR_COUNT_EN
    .cnt_clr(1'b0), .edge_count(cnt_w4),
`endif
    .negedge_detected(out_w4)
  );

  negedge_detector #(.WIDTH(1), .SYNC_STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .signal_in(sig_s2),
`ifdef NEGEDGE_DETECTOR_COUNT_EN
    .cnt_clr(1'b0), .edge_count(cnt_s2),
`endif
    .negedge_detected(out_s2)
  );

`ifdef NEGEDGE_DETECTOR_COUNT_EN
  negedge_detector #(.WIDTH(1), .SYNC_STAGES(0), .CNT_WIDTH(2)) u_cnt (
    .clk(clk), .rst_n(rst_n), .signal_in(sig_c),
    .cnt_clr(cnt_clr), .edge_count(cnt_c),
    .negedge_detected(out_c)
  );
`endif

  typedef struct {
    logic [3:0] in;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 4'b0000};
    vecs[1]  = '{4'b0101, 4'b1010};
    vecs[2]  = '{4'b0000, 4'b0101};
    vecs[3]  = '{4'b0000, 4'b0000};
    vecs[4]  = '{4'b1010, 4'b0000};
    vecs[5]  = '{4'b0101, 4'b1010};
    vecs[6]  = '{4'b1010, 4'b0101};
    vecs[7]  = '{4'b1111, 4'b0000};
    vecs[8]  = '{4'b0000, 4'b1111};
    vecs[9]  = '{4'b1001, 4'b0000};
    vecs[10] = '{4'b0110, 4'b1001};
    vecs[11] = '{4'b0110, 4'b0000};

    rst_n  = 1'b0;
    sig_w1 = 1'b1;
    sig_w4 = 4'b1111;
    sig_s2 = 1'b1;
`ifdef NEGEDGE_DETECTOR_COUNT_EN
    sig_c   = 1'b1;
    cnt_clr = 1'b0;
`endif

    // Absolute-time basic fall and synchronizer latency (edges at 5,15,25,...)
    #18;
    chk("reset_w1", 32'(out_w1), 32'd0);
    chk("reset_w4", 32'(out_w4), 32'd0);
    chk("reset_s2", 32'(out_s2), 32'd0);
    #2;  rst_n = 1'b1;                           // t=20
    #20; chk("basic_before", 32'(out_w1), 32'd0); // t=40
    #2;  sig_w1 = 1'b0; sig_s2 = 1'b0;            // t=42
    #8;  chk("basic_pulse", 32'(out_w1), 32'd1);  // t=50
    #10; chk("basic_after", 32'(out_w1), 32'd0);  // t=60
    chk("sync_before", 32'(out_s2), 32'd0);
    #10; chk("sync_pulse", 32'(out_s2), 32'd1);   // t=70
    #10; chk("sync_after", 32'(out_s2), 32'd0);   // t=80

    // Held low then rise: one pulse only, none on the rise
    @(negedge clk);
    sig_w1 = 1'b1; cyc(); chk("rise_nopulse", 32'(out_w1), 32'd0);
    sig_w1 = 1'b0; cyc(); chk("fall2_pulse", 32'(out_w1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("held_low", 32'(out_w1), 32'd0);
    end
    sig_w1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("held_high", 32'(out_w1), 32'd0);
    end

    // Input low through reset release never pulses
    rst_n = 1'b0; sig_w1 = 1'b0;
    cyc(); cyc(); chk("rst_low_in", 32'(out_w1), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("release_low", 32'(out_w1), 32'd0);
    end
    // High then fall after release pulses
    sig_w1 = 1'b1; cyc(); cyc();
    sig_w1 = 1'b0; cyc(); chk("release_fall", 32'(out_w1), 32'd1);

    // Reset at the edge where a pulse would appear clears it
    sig_w1 = 1'b1; cyc(); cyc();
    sig_w1 = 1'b0; rst_n = 1'b0; cyc(); chk("rst_kills_pulse", 32'(out_w1), 32'd0);
    rst_n = 1'b1; cyc(); chk("rst_kills_after", 32'(out_w1), 32'd0);
    // Reset asserted while the pulse is high clears it at the next edge
    sig_w1 = 1'b1; cyc(); cyc();
    sig_w1 = 1'b0; cyc(); chk("pulse_hi", 32'(out_w1), 32'd1);
    rst_n = 1'b0; cyc(); chk("rst_mid_pulse", 32'(out_w1), 32'd0);

    // Multi-lane table, starting from a cleared prev register
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sig_w4 = vecs[i].in;
      cyc();
      chk($sformatf("lanes[%0d]", i), 32'(out_w4), 32'(vecs[i].exp));
    end

`ifdef NEGEDGE_DETECTOR_COUNT_EN
    // Counter saturates at 3 with CNT_WIDTH=2
    rst_n = 1'b0; sig_c = 1'b1; cyc();
    rst_n = 1'b1; cyc(); cyc();
    chk("cnt_reset", 32'(cnt_c), 32'd0);
    for (int i = 0; i < 5; i++) begin
      sig_c = 1'b0; cyc();
      chk($sformatf("cnt_fall[%0d]", i), 32'(cnt_c), (i < 3) ? 32'(i + 1) : 32'd3);
      sig_c = 1'b1; cyc();
    end
    // Clear wins over a simultaneous increment
    sig_c = 1'b0; cnt_clr = 1'b1; cyc();
    chk("cnt_clr_pulse", 32'(out_c), 32'd1);
    chk("cnt_clr", 32'(cnt_c), 32'd0);
    cnt_clr = 1'b0; cyc(); chk("cnt_after_clr", 32'(cnt_c), 32'd0);
    sig_c = 1'b1; cyc(); chk("cnt_rise", 32'(cnt_c), 32'd0);
    sig_c = 1'b0; cyc(); chk("cnt_one", 32'(cnt_c), 32'd1);
    rst_n = 1'b0; cyc(); chk("cnt_rst", 32'(cnt_c), 32'd0);
    rst_n = 1'b1; cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
